// File: rtl/uart_pkg.sv
// Shared definitions for the uart_byte_link serial front end: FSM state
// encodings (used by both the TX and RX machines), the line idle level and
// the baud divider helper.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // A UART line rests at mark (high) between frames.
    localparam logic UART_IDLE = 1'b1;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync.sv
// Two-flop synchroniser for a single asynchronous input. RST_VAL lets a
// line that idles high come out of reset without a false edge.
module sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte storage between the bus-side capture logic and the TX shifter.
// Build switch UART_TX_FIFO_EN: defined -> DEPTH-entry circular FIFO,
// undefined -> a single holding register.
//
// Handshake: push is a request qualified by nothing else; it is accepted
// when the store is not full, or when it is full and pop happens in the same
// cycle (the pop frees the slot). A push that is not accepted drops the byte
// and raises overflow for one cycle. pop must only be asserted while empty is
// low; pop_data is valid whenever empty is low and refers to the oldest byte.
module uart_tx_fifo
`ifdef UART_TX_FIFO_EN
#(
    parameter int DEPTH = 16
)
`endif
(
    input  logic       clk12,
    input  logic       rstn,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       empty,
    output logic       full,
    output logic       overflow
);

    logic accept;

    assign accept = push && (!full || pop);

    // One-cycle pulse for every byte that had nowhere to go.
    always_ff @(posedge clk12 or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else begin
            overflow <= push && !accept;
        end
    end

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; both may move in the same cycle.
    always_ff @(posedge clk12 or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk12) begin
        if (accept) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end
`else
    logic [7:0] hold_q;
    logic       hold_valid;

    assign empty    = !hold_valid;
    assign full     = hold_valid;
    assign pop_data = hold_q;

    // Single holding register: a new byte may replace one being popped.
    always_ff @(posedge clk12 or negedge rstn) begin
        if (!rstn) begin
            hold_q     <= 8'h00;
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold_q     <= push_data;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/uart_byte_link.sv
// uart_byte_link: 8N1 UART between the RX/TX pins and the byte registers of
// the 68000 bus responder. A write of a nonzero TX_data is captured once per
// bus cycle and queued; received bytes appear on RX_data with a rx_valid
// pulse. Build switch UART_TX_FIFO_EN selects a FIFO instead of a single
// holding register for the TX queue. Both FSM states are exported for debug.
module uart_byte_link
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk12,
    input  logic       rstn,
    input  logic       RX,
    output logic       TX,
    input  logic [7:0] TX_data,
    output logic [7:0] RX_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       tx_busy,
    output logic       tx_overflow,
    output logic [1:0] tx_state_dbg,
    output logic [1:0] rx_state_dbg
);

    localparam int DIV = uart_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    // Refuse to build with a divider too small to find a bit centre or a
    // FIFO depth the wrapping pointers cannot represent.
    if (DIV < 4 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_byte_link: DIV must be >= 4 and FIFO_DEPTH a power of two >= 2");
    end

    // ------------------------------------------------------------------
    // TX capture: the bus holds TX_data for the whole write, so only the
    // 0x00 -> nonzero transition counts as a new byte.
    // ------------------------------------------------------------------
    logic [7:0] tx_data_q;
    logic       tx_push;

    // Previous-cycle copy of the bus byte for edge detection.
    always_ff @(posedge clk12 or negedge rstn) begin
        if (!rstn) begin
            tx_data_q <= 8'h00;
        end else begin
            tx_data_q <= TX_data;
        end
    end

    assign tx_push = (TX_data != 8'h00) && (tx_data_q == 8'h00);

    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_pop;

    uart_tx_fifo
`ifdef UART_TX_FIFO_EN
        #(.DEPTH(FIFO_DEPTH))
`endif
        u_tx_fifo (
        .clk12     (clk12),
        .rstn      (rstn),
        .push      (tx_push),
        .push_data (TX_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .overflow  (tx_overflow)
    );

    // ------------------------------------------------------------------
    // TX shifter
    // ------------------------------------------------------------------
    logic [1:0]    tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_sh;
    logic          tx_q;

    // A byte leaves the queue when a frame starts: from IDLE, or straight out
    // of the last STOP cycle for back-to-back frames.
    assign fifo_pop = !fifo_empty &&
                      ((tx_state == ST_IDLE) ||
                       (tx_state == ST_STOP && tx_cnt == '0));

    // Frame sequencer; TX is a register so the pin never glitches.
    always_ff @(posedge clk12 or negedge rstn) begin
        if (!rstn) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= 3'd0;
            tx_sh    <= 8'h00;
            tx_q     <= UART_IDLE;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        tx_state <= ST_START;
                        tx_cnt   <= BIT_LAST;
                        tx_sh    <= fifo_data;
                        tx_q     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_cnt == '0) begin
                        tx_state <= ST_DATA;
                        tx_cnt   <= BIT_LAST;
                        tx_idx   <= 3'd0;
                        tx_q     <= tx_sh[0];
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= BIT_LAST;
                        if (tx_idx == 3'd7) begin
                            tx_state <= ST_STOP;
                            tx_q     <= UART_IDLE;
                        end else begin
                            tx_idx <= tx_idx + 3'd1;
                            tx_sh  <= {1'b0, tx_sh[7:1]};
                            tx_q   <= tx_sh[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == '0) begin
                        if (fifo_pop) begin
                            tx_state <= ST_START;
                            tx_cnt   <= BIT_LAST;
                            tx_sh    <= fifo_data;
                            tx_q     <= 1'b0;
                        end else begin
                            tx_state <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    assign TX           = tx_q;
    assign tx_busy      = (tx_state != ST_IDLE) || !fifo_empty;
    assign tx_state_dbg = tx_state;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic rx_s;
    logic rx_prev;

    sync #(.RST_VAL(UART_IDLE)) u_rx_sync (
        .clk  (clk12),
        .rstn (rstn),
        .d    (RX),
        .q    (rx_s)
    );

    // Delayed synced line for falling-edge detection. After a framing error
    // the line must be seen high here before a new edge can re-arm.
    always_ff @(posedge clk12 or negedge rstn) begin
        if (!rstn) begin
            rx_prev <= UART_IDLE;
        end else begin
            rx_prev <= rx_s;
        end
    end

    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_sh;

    // Receiver: half a bit to the start centre, then whole bits to each
    // data centre and the stop centre.
    always_ff @(posedge clk12 or negedge rstn) begin
        if (!rstn) begin
            rx_state     <= ST_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= 3'd0;
            rx_sh        <= 8'h00;
            RX_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (rx_state)
                ST_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= ST_START;
                        rx_cnt   <= HALF_LAST;
                    end
                end
                ST_START: begin
                    if (rx_cnt == '0) begin
                        if (!rx_s) begin
                            rx_state <= ST_DATA;
                            rx_cnt   <= BIT_LAST;
                            rx_idx   <= 3'd0;
                        end else begin
                            rx_state <= ST_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_cnt <= BIT_LAST;
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        if (rx_idx == 3'd7) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt == '0) begin
                        rx_state <= ST_IDLE;
                        if (rx_s) begin
                            RX_data  <= rx_sh;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_state_dbg = rx_state;

endmodule

// File: tb/tb_uart_byte_link.sv
// Testbench for uart_byte_link: reset values, a table of RX frames, random RX
// frames, glitch rejection, an exact single TX frame, TX bursts checked
// against a queue-occupancy model, and reset in the middle of a frame.
module tb_uart_byte_link;

    localparam int DIV = (12000000 + 115200 / 2) / 115200;
`ifdef UART_TX_FIFO_EN
    localparam int TX_SLOTS = 16;
`else
    localparam int TX_SLOTS = 1;
`endif

    logic       clk12 = 1'b0;
    logic       rstn  = 1'b0;
    logic       RX    = 1'b1;
    logic       TX;
    logic [7:0] TX_data = 8'h00;
    logic [7:0] RX_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       tx_busy;
    logic       tx_overflow;
    logic [1:0] tx_state_dbg;
    logic [1:0] rx_state_dbg;

    uart_byte_link dut (
        .clk12        (clk12),
        .rstn         (rstn),
        .RX           (RX),
        .TX           (TX),
        .TX_data      (TX_data),
        .RX_data      (RX_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .tx_busy      (tx_busy),
        .tx_overflow  (tx_overflow),
        .tx_state_dbg (tx_state_dbg),
        .rx_state_dbg (rx_state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk12 = ~clk12;

    int cyc = 0;
    always @(posedge clk12) cyc++;

    initial begin
        repeat (99000) @(posedge clk12);
        $display("FAIL watchdog: cycle budget of 99000 exhausted");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk12);
    endtask

    // Pulse counters (each counts cycles the output is high).
    int n_valid = 0;
    int n_err   = 0;
    int n_ovf   = 0;
    always @(negedge clk12) begin
        if (rstn) begin
            if (rx_valid)     n_valid++;
            if (rx_frame_err) n_err++;
            if (tx_overflow)  n_ovf++;
        end
    end

    // ---------------- TX line monitor (independent UART receiver) ----------------
    logic [7:0] tx_got[$];
    int         tx_stop_err = 0;
    logic [7:0] mon_b;
    initial begin
        forever begin
            @(negedge clk12);
            if (rstn && TX == 1'b0) begin
                tick(DIV / 2 - 1);
                if (TX == 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        tick(DIV);
                        mon_b[i] = TX;
                    end
                    tick(DIV);
                    if (TX !== 1'b1) tx_stop_err++;
                    tx_got.push_back(mon_b);
                end
            end
        end
    end

    // ---------------- RX driver ----------------
    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int idle);
        RX = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(DIV);
        end
        RX = stop_bit;
        tick(DIV);
        RX = 1'b1;
        tick(idle);
    endtask

    // ---------------- TX queue model ----------------
    // A byte occupies storage from its push edge until it is handed to the
    // shifter; hand-over happens one cycle after the push, or when the line
    // finishes the previous 10-bit frame, whichever is later.
    logic [7:0] exp_q[$];
    int         model_pops[$];
    int         model_free_t = 0;
    int         exp_ovf      = 0;

    task automatic tx_write(input logic [7:0] val, input int hold, input int gap, input bit alt);
        int c, occ, pop_t;
        TX_data = val;
        c = cyc + 1;
        occ = 0;
        foreach (model_pops[j]) if (model_pops[j] > c) occ++;
        if (occ < TX_SLOTS) begin
            pop_t = (model_free_t > c + 1) ? model_free_t : c + 1;
            model_free_t = pop_t + 10 * DIV;
            model_pops.push_back(pop_t);
            exp_q.push_back(val);
        end else begin
            exp_ovf++;
        end
        tick(1);
        if (alt && hold > 1) TX_data = 8'($urandom_range(1, 255));
        tick(hold - 1);
        TX_data = 8'h00;
        tick(gap);
    endtask

    task automatic tx_drain_and_compare(input string tag);
        while (cyc < model_free_t - 1) @(negedge clk12);
        check({tag, "_busy_last_stop"}, tx_busy, 1'b1);
        tick(1);
        check({tag, "_busy_falls"}, tx_busy, 1'b0);
        check({tag, "_frame_count"}, tx_got.size(), exp_q.size());
        check({tag, "_overflow_count"}, n_ovf, exp_ovf);
        for (int i = 0; i < exp_q.size() && i < tx_got.size(); i++)
            check({tag, "_byte"}, tx_got[i], exp_q[i]);
        tx_got.delete();
        exp_q.delete();
        model_pops.delete();
        n_ovf   = 0;
        exp_ovf = 0;
    endtask

    // ---------------- RX vector table ----------------
    typedef struct {
        logic [7:0] rx_byte;
        logic       stop_bit;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_data;
    } rx_vec_t;

    rx_vec_t    vecs[6];
    int         lat;
    int         v0, e0;
    logic [7:0] exp_rx;
    logic [7:0] rb;
    logic       sb;
    logic [7:0] tb_byte;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 0, 1, 8'h5A};
        vecs[1] = '{8'h33, 1'b1, 1, 0, 8'h33};
        vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[4] = '{8'h80, 1'b0, 0, 1, 8'hFF};
        vecs[5] = '{8'h01, 1'b1, 1, 0, 8'h01};

        // ---- reset values ----
        tick(5);
        check("rst_tx", TX, 1'b1);
        check("rst_rx_data", RX_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_frame_err", rx_frame_err, 1'b0);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_tx_overflow", tx_overflow, 1'b0);
        check("rst_tx_state", tx_state_dbg, 2'd0);
        check("rst_rx_state", rx_state_dbg, 2'd0);
        rstn = 1'b1;
        tick(3);
        check("post_rst_tx_idle", TX, 1'b1);

        // ---- good RX frame with latency window ----
        v0 = n_valid;
        lat = 0;
        fork
            send_rx(8'h5A, 1'b1, 8);
            begin
                while (!rx_valid && lat < 12 * DIV) begin
                    @(negedge clk12);
                    lat++;
                end
            end
        join
        check("rx_valid_latency_ok", (lat >= 986 && lat <= 996), 1'b1);
        check("rx_first_data", RX_data, 8'h5A);
        check("rx_first_valid_count", n_valid - v0, 1);

        // ---- table of RX frames ----
        foreach (vecs[i]) begin
            v0 = n_valid;
            e0 = n_err;
            send_rx(vecs[i].rx_byte, vecs[i].stop_bit, 20);
            check("rx_tab_valid", n_valid - v0, vecs[i].exp_valid);
            check("rx_tab_err", n_err - e0, vecs[i].exp_err);
            check("rx_tab_data", RX_data, vecs[i].exp_data);
        end

        // ---- random RX frames against last-good-byte model ----
        exp_rx = 8'h01;
        for (int k = 0; k < 8; k++) begin
            rb = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 3) != 0);
            v0 = n_valid;
            e0 = n_err;
            send_rx(rb, sb, $urandom_range(4, 2 * DIV));
            if (sb) exp_rx = rb;
            check("rx_rand_valid", n_valid - v0, sb ? 1 : 0);
            check("rx_rand_err", n_err - e0, sb ? 0 : 1);
            check("rx_rand_data", RX_data, exp_rx);
        end

        // ---- glitch rejection ----
        v0 = n_valid;
        e0 = n_err;
        RX = 1'b0;
        tick(20);
        RX = 1'b1;
        tick(3 * DIV);
        check("glitch_no_valid", n_valid - v0, 0);
        check("glitch_no_err", n_err - e0, 0);
        check("glitch_rx_idle", rx_state_dbg, 2'd0);
        check("glitch_data_kept", RX_data, exp_rx);

        // ---- single TX byte, bit-exact ----
        tb_byte = 8'h41;
        TX_data = tb_byte;
        tick(1);
        check("tx_before_edge", TX, 1'b1);
        check("tx_busy_queued", tx_busy, 1'b1);
        tick(1);
        check("tx_falls_2cyc", TX, 1'b0);
        tick(6);
        TX_data = 8'h00;
        tick(45);
        check("tx_start_bit", TX, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(DIV);
            check("tx_data_bit", TX, tb_byte[i]);
        end
        tick(DIV);
        check("tx_stop_bit", TX, 1'b1);
        tick(DIV / 2);
        check("tx_busy_end_stop", tx_busy, 1'b1);
        tick(1);
        check("tx_busy_after_stop", tx_busy, 1'b0);
        check("tx_one_frame", tx_got.size(), 1);
        if (tx_got.size() > 0) check("tx_single_byte", tx_got[0], tb_byte);
        tx_got.delete();
        n_ovf = 0;
        tick(10);

        // ---- deterministic burst 0x31..0x42 spaced 10 cycles ----
        for (int k = 0; k < 18; k++) tx_write(8'(8'h31 + k), 5, 5, 1'b0);
        tx_drain_and_compare("burst");

        // ---- random bursts: values, hold, spacing, nonzero->nonzero changes ----
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++)
                tx_write(8'($urandom_range(1, 255)), $urandom_range(1, 4),
                         $urandom_range(5, 300), 1'($urandom_range(0, 1)));
            tx_drain_and_compare("rand");
        end
        check("tx_monitor_stop_bits", tx_stop_err, 0);

        // ---- reset in the middle of a frame ----
        TX_data = 8'h55;
        tick(1);
        TX_data = 8'h00;
        tick(41);
        check("midframe_tx_low", TX, 1'b0);
        #2 rstn = 1'b0;
        #1;
        check("midframe_rst_tx_high", TX, 1'b1);
        check("midframe_rst_busy", tx_busy, 1'b0);
        check("midframe_rst_state", tx_state_dbg, 2'd0);
        tick(2);
        rstn = 1'b1;
        tick(2);
        check("midframe_after_release_tx", TX, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
